rw_port_ram_arbiter: RTL and testbench

//  Shares one rw_port_ram instance (1 read port, 1 write port, 1-cycle registered read) between two masters.

---
 rtl/rw_port_ram_arbiter.sv | 131 +++++++++++++
 tb/tb_rw_port_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rw_port_ram_arbiter.sv
// rw_port_ram_arbiter
//   Shares one single-read-port / single-write-port RAM (1-cycle registered
//   read) between two masters. The read port and the write port each have
//   their own round-robin arbiter, so a read and a write can be granted in
//   the same cycle. Read data comes back to the granted master as a one-cycle
//   response pulse the cycle after the grant.
//
// Ports
//   i_clk, i_reset_n              clock, synchronous active-low reset
//   i_mX_rd_valid / i_mX_rd_addr  master X read request
//   o_mX_rd_ready                 master X read accepted this cycle
//   o_mX_rsp_valid / o_mX_rsp_data master X read response (one cycle after accept)
//   i_mX_wr_valid / _addr / _data master X write request
//   o_mX_wr_ready                 master X write accepted this cycle
//   o_ram_addr_r                  RAM read address
//   o_ram_addr_w / o_ram_data_in  RAM write address / data
//   o_ram_we                      RAM write enable
//   i_ram_data_out                RAM registered read data
module rw_port_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  // master 0
  input  logic                  i_m0_rd_valid,
  input  logic [ADDR_WIDTH-1:0] i_m0_rd_addr,
  output logic                  o_m0_rd_ready,
  output logic                  o_m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_m0_rsp_data,
  input  logic                  i_m0_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_m0_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_wr_data,
  output logic                  o_m0_wr_ready,
  // master 1
  input  logic                  i_m1_rd_valid,
  input  logic [ADDR_WIDTH-1:0] i_m1_rd_addr,
  output logic                  o_m1_rd_ready,
  output logic                  o_m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_m1_rsp_data,
  input  logic                  i_m1_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_m1_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wr_data,
  output logic                  o_m1_wr_ready,
  // RAM side
  output logic [ADDR_WIDTH-1:0] o_ram_addr_r,
  output logic [ADDR_WIDTH-1:0] o_ram_addr_w,
  output logic [DATA_WIDTH-1:0] o_ram_data_in,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data_out
);

  // Round-robin state: index of the master granted most recently on each port.
  logic                  r_rd_last;
  logic                  r_wr_last;
  // Outstanding read response (owner is the master granted last cycle).
  logic                  r_rsp_pending;
  logic                  r_rsp_owner;
  // Read address presented while no read is granted.
  logic [ADDR_WIDTH-1:0] r_addr_r_hold;

  logic w_rd_gnt0;
  logic w_rd_gnt1;
  logic w_wr_gnt0;
  logic w_wr_gnt1;
  logic w_rd_any;
  logic w_wr_any;

  // On a tie the master that was not granted last wins. Grants are blocked
  // while in reset, which also keeps the RAM write enable low.
  always_comb begin
    w_rd_gnt0 = i_reset_n && i_m0_rd_valid && (!i_m1_rd_valid || r_rd_last);
    w_rd_gnt1 = i_reset_n && i_m1_rd_valid && (!i_m0_rd_valid || !r_rd_last);
    w_wr_gnt0 = i_reset_n && i_m0_wr_valid && (!i_m1_wr_valid || r_wr_last);
    w_wr_gnt1 = i_reset_n && i_m1_wr_valid && (!i_m0_wr_valid || !r_wr_last);
    w_rd_any  = w_rd_gnt0 || w_rd_gnt1;
    w_wr_any  = w_wr_gnt0 || w_wr_gnt1;
  end

  assign o_m0_rd_ready = w_rd_gnt0;
  assign o_m1_rd_ready = w_rd_gnt1;
  assign o_m0_wr_ready = w_wr_gnt0;
  assign o_m1_wr_ready = w_wr_gnt1;

  // Read address follows the winner; otherwise keep the last granted one so
  // the RAM address bus does not toggle needlessly.
  always_comb begin
    o_ram_addr_r = r_addr_r_hold;
    if (w_rd_gnt1) begin
      o_ram_addr_r = i_m1_rd_addr;
    end else if (w_rd_gnt0) begin
      o_ram_addr_r = i_m0_rd_addr;
    end
  end

  // Write bus only matters when o_ram_we is high.
  assign o_ram_we      = w_wr_any;
  assign o_ram_addr_w  = w_wr_gnt1 ? i_m1_wr_addr : i_m0_wr_addr;
  assign o_ram_data_in = w_wr_gnt1 ? i_m1_wr_data : i_m0_wr_data;

  // The RAM is read-before-write, so a same-cycle read of a written address
  // returns the old contents; no forwarding is added here.
  // Response valid is also gated by reset so a grant just before reset
  // assertion never surfaces.
  assign o_m0_rsp_valid = i_reset_n && r_rsp_pending && !r_rsp_owner;
  assign o_m1_rsp_valid = i_reset_n && r_rsp_pending &&  r_rsp_owner;
  assign o_m0_rsp_data  = i_ram_data_out;
  assign o_m1_rsp_data  = i_ram_data_out;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rsp_pending <= 1'b0;
      r_rsp_owner   <= 1'b0;
      // last = master1 so master0 takes the first tie after reset
      r_rd_last     <= 1'b1;
      r_wr_last     <= 1'b1;
      r_addr_r_hold <= '0;
    end else begin
      r_rsp_pending <= w_rd_any;
      if (w_rd_any) begin
        r_rsp_owner   <= w_rd_gnt1;
        r_rd_last     <= w_rd_gnt1;
        r_addr_r_hold <= o_ram_addr_r;
      end
      if (w_wr_any) begin
        r_wr_last <= w_wr_gnt1;
      end
    end
  end

endmodule

// File: tb/tb_rw_port_ram_arbiter.sv
// tb_rw_port_ram_arbiter
//   Drives both masters of rw_port_ram_arbiter with directed and random
//   requests, models the external RAM, and checks grants and read responses
//   against a reference model (shadow memory + round-robin preference).
module tb_rw_port_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_rd_valid = 1'b0, m1_rd_valid = 1'b0;
  logic [AW-1:0] m0_rd_addr = '0, m1_rd_addr = '0;
  logic          m0_rd_ready, m1_rd_ready;
  logic          m0_rsp_valid, m1_rsp_valid;
  logic [DW-1:0] m0_rsp_data, m1_rsp_data;
  logic          m0_wr_valid = 1'b0, m1_wr_valid = 1'b0;
  logic [AW-1:0] m0_wr_addr = '0, m1_wr_addr = '0;
  logic [DW-1:0] m0_wr_data = '0, m1_wr_data = '0;
  logic          m0_wr_ready, m1_wr_ready;
  logic [AW-1:0] ram_addr_r, ram_addr_w;
  logic [DW-1:0] ram_data_in;
  logic          ram_we;
  logic [DW-1:0] ram_data_out = '0;

  always #5 clk = ~clk;

  rw_port_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_m0_rd_valid(m0_rd_valid), .i_m0_rd_addr(m0_rd_addr), .o_m0_rd_ready(m0_rd_ready),
    .o_m0_rsp_valid(m0_rsp_valid), .o_m0_rsp_data(m0_rsp_data),
    .i_m0_wr_valid(m0_wr_valid), .i_m0_wr_addr(m0_wr_addr), .i_m0_wr_data(m0_wr_data),
    .o_m0_wr_ready(m0_wr_ready),
    .i_m1_rd_valid(m1_rd_valid), .i_m1_rd_addr(m1_rd_addr), .o_m1_rd_ready(m1_rd_ready),
    .o_m1_rsp_valid(m1_rsp_valid), .o_m1_rsp_data(m1_rsp_data),
    .i_m1_wr_valid(m1_wr_valid), .i_m1_wr_addr(m1_wr_addr), .i_m1_wr_data(m1_wr_data),
    .o_m1_wr_ready(m1_wr_ready),
    .o_ram_addr_r(ram_addr_r), .o_ram_addr_w(ram_addr_w), .o_ram_data_in(ram_data_in),
    .o_ram_we(ram_we), .i_ram_data_out(ram_data_out)
  );

  // External RAM: registered read, read-before-write.
  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr_w] <= ram_data_in;
    ram_data_out <= ram[ram_addr_r];
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          owner;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] mdl_mem [0:(1<<AW)-1] = '{default: '0};
  int rd_fav = 0;   // master that wins the next read tie
  int wr_fav = 0;
  int rd_win, wr_win;

  // Pending requests: each held until granted.
  bit            rq_v [2];
  logic [AW-1:0] rq_a [2];
  bit            wq_v [2];
  logic [AW-1:0] wq_a [2];
  logic [DW-1:0] wq_d [2];
  logic          rst_n_nxt = 1'b0;

  function automatic int pick(bit en, bit v0, bit v1, int fav);
    if (!en) return -1;
    if (v0 && v1) return fav;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // One clock cycle: drive pending requests, then check grants at the
  // falling edge and advance the model.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n_nxt) sbq.delete();  // in-flight response is squashed by reset
    reset_n     = rst_n_nxt;
    m0_rd_valid = rq_v[0]; m0_rd_addr = rq_a[0];
    m1_rd_valid = rq_v[1]; m1_rd_addr = rq_a[1];
    m0_wr_valid = wq_v[0]; m0_wr_addr = wq_a[0]; m0_wr_data = wq_d[0];
    m1_wr_valid = wq_v[1]; m1_wr_addr = wq_a[1]; m1_wr_data = wq_d[1];
    @(negedge clk);
    rd_win = pick(reset_n, rq_v[0], rq_v[1], rd_fav);
    wr_win = pick(reset_n, wq_v[0], wq_v[1], wr_fav);
    chk("m0_rd_ready", m0_rd_ready, rd_win == 0);
    chk("m1_rd_ready", m1_rd_ready, rd_win == 1);
    chk("m0_wr_ready", m0_wr_ready, wr_win == 0);
    chk("m1_wr_ready", m1_wr_ready, wr_win == 1);
    chk("ram_we", ram_we, wr_win >= 0);
    if (rd_win >= 0) begin
      chk("ram_addr_r", ram_addr_r, rq_a[rd_win]);
      e.due = cyc + 1; e.owner = rd_win; e.data = mdl_mem[rq_a[rd_win]];
      sbq.push_back(e);
      rd_fav = 1 - rd_win;
      rq_v[rd_win] = 0;
    end
    if (wr_win >= 0) begin
      chk("ram_addr_w", ram_addr_w, wq_a[wr_win]);
      chk("ram_data_in", ram_data_in, wq_d[wr_win]);
      mdl_mem[wq_a[wr_win]] = wq_d[wr_win];
      wr_fav = 1 - wr_win;
      wq_v[wr_win] = 0;
    end
    if (!reset_n) begin
      rd_fav = 0;
      wr_fav = 0;
    end
  endtask

  // ---------------- response monitor ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("m0_rsp_valid", m0_rsp_valid, e.owner == 0);
      chk("m1_rsp_valid", m1_rsp_valid, e.owner == 1);
      chk("rsp_data", (e.owner == 0) ? m0_rsp_data : m1_rsp_data, e.data);
      $display("[TB] cyc %0d rsp m%0d data %02h (exp %02h)", cyc, e.owner,
               (e.owner == 0) ? m0_rsp_data : m1_rsp_data, e.data);
    end else begin
      chk("m0_rsp_idle", m0_rsp_valid, 0);
      chk("m1_rsp_idle", m1_rsp_valid, 0);
    end
  end

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      rq_v[i] = 0; rq_a[i] = '0; wq_v[i] = 0; wq_a[i] = '0; wq_d[i] = '0;
    end
  endtask

  task automatic do_reset(input int n);
    clear_reqs();
    rst_n_nxt = 1'b0;
    repeat (n) cycle();
    rst_n_nxt = 1'b1;
  endtask

  initial begin
    clear_reqs();
    do_reset(3);

    // 1: write then read back
    wq_v[0] = 1; wq_a[0] = 12'h010; wq_d[0] = 8'hA5;
    cycle();
    chk("t1_wr_win", wr_win, 0);
    rq_v[0] = 1; rq_a[0] = 12'h010;
    cycle();
    chk("t1_rd_win", rd_win, 0);
    cycle();

    // 2: continuous read contention alternates starting with m0
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      rq_v[0] = 1; rq_a[0] = 12'(i);
      rq_v[1] = 1; rq_a[1] = 12'(16 + i);
      cycle();
      chk("t2_rd_alt", rd_win, i % 2);
    end
    clear_reqs();
    cycle();

    // 3: simultaneous writes to one address, later read returns m1's data
    do_reset(1);
    wq_v[0] = 1; wq_a[0] = 12'h020; wq_d[0] = 8'h11;
    wq_v[1] = 1; wq_a[1] = 12'h020; wq_d[1] = 8'h22;
    cycle();
    chk("t3_first", wr_win, 0);
    cycle();
    chk("t3_second", wr_win, 1);
    rq_v[0] = 1; rq_a[0] = 12'h020;
    cycle();
    cycle();

    // 4: same-cycle read and write of 0x030 returns old data, next read new
    rq_v[0] = 1; rq_a[0] = 12'h030;
    wq_v[1] = 1; wq_a[1] = 12'h030; wq_d[1] = 8'h5A;
    cycle();
    rq_v[1] = 1; rq_a[1] = 12'h030;
    cycle();
    cycle();

    // 5: reset right after an m1 read grant
    rq_v[1] = 1; rq_a[1] = 12'h123;
    cycle();
    chk("t5_m1_gnt", rd_win, 1);
    rq_v[0] = 1; rq_v[1] = 1; rq_a[1] = 12'h124;
    wq_v[0] = 1; wq_a[0] = 12'h040; wq_d[0] = 8'h77;
    rst_n_nxt = 1'b0;
    cycle();
    cycle();
    rst_n_nxt = 1'b1;
    cycle();
    chk("t5_tie_m0", rd_win, 0);
    chk("t5_wr_after", wr_win, 0);
    clear_reqs();
    cycle();

    // 6: m1 alone for three cycles, then m0 wins the tie
    for (int i = 0; i < 3; i++) begin
      rq_v[1] = 1; rq_a[1] = 12'(32 + i);
      cycle();
      chk("t6_m1_alone", rd_win, 1);
    end
    rq_v[0] = 1; rq_a[0] = 12'h050;
    rq_v[1] = 1; rq_a[1] = 12'h051;
    cycle();
    chk("t6_tie_m0", rd_win, 0);
    cycle();
    cycle();

    // random traffic over a small address window to force collisions
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!rq_v[m] && $urandom_range(0, 1) == 1) begin
          rq_v[m] = 1; rq_a[m] = 12'($urandom_range(0, 15));
        end
        if (!wq_v[m] && $urandom_range(0, 2) == 0) begin
          wq_v[m] = 1; wq_a[m] = 12'($urandom_range(0, 15));
          wq_d[m] = 8'($urandom_range(0, 255));
        end
      end
      rst_n_nxt = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n_nxt = 1'b1;
    clear_reqs();
    repeat (3) cycle();
    chk("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
